rom_mem_port_sched: RTL and testbench
=====================================

// Module: rom_mem_port_sched
// PURPOSE
//  Sequences one port of the dual-port rom_mem and shares it between two requesters:
//  P0 (ioctl loader, writes) and P1 (CPU/video fetch, reads).
//  Grants requesters round-robin, drives the port with the setup/hold timing it needs
//  (address/wren registered inside rom_mem, data_a sampled one cycle later),
//  and returns read data with a single-cycle ack.
//  Sits between the requesters and the rom_mem a-port (or b-port); the other port stays free.
// PARAMETERS
//  DATAWIDTH  8   width of memory word and wdata/rdata
//  ADDRWIDTH  14  width of memory address
// PORTS
//  clock        in   1          single clock; also clocks the rom_mem port
//  reset_n      in   1          asynchronous, active-low reset
//  p0_req       in   1          P0 request; level, held until p0_ack
//  p0_we        in   1          P0 write (1) / read (0); stable while p0_req
//  p0_addr      in   ADDRWIDTH  P0 address; stable while p0_req
//  p0_wdata     in   DATAWIDTH  P0 write data; stable while p0_req
//  p0_ack       out  1          one-cycle completion pulse for P0
//  p1_req/p1_we/p1_addr/p1_wdata/p1_ack  same as P0, for P1
//  rdata        out  DATAWIDTH  read data of last completed read; valid in and after its ack cycle
//  busy         out  1          access in flight (state != IDLE)
//  mem_addr     out  ADDRWIDTH  to rom_mem address_x
//  mem_data     out  DATAWIDTH  to rom_mem data_x
//  mem_wren     out  1          to rom_mem wren_x
//  mem_q        in   DATAWIDTH  from rom_mem q_x
// BEHAVIOUR
//  Reset values
//   - State: IDLE.
//   - Outputs: all outputs 0.
//   - last_grant: P1, so P0 wins the first tie.
//  FSM: IDLE -> ADDR -> MEM -> DATA -> IDLE. All outputs are registered.
//  IDLE (cycle N)
//   - Eligible request: pX_req high, excluding any port whose ack is high this cycle.
//   - One eligible request: grant it.
//   - Both eligible: grant the port not equal to last_grant, then update last_grant.
//   - On grant, latch we/addr/wdata and load mem_addr/mem_data/mem_wren=we; go to ADDR.
//   - No eligible request: stay in IDLE.
//  ADDR (cycle N+1)
//   - mem_* valid; rom_mem registers address and wren at the end of this cycle.
//   - Next cycle, mem_wren returns to 0.
//  MEM (cycle N+2)
//   - mem_addr and mem_data held unchanged; the write is committed here.
//   - mem_q is valid at N+3.
//  DATA (cycle N+3)
//   - Capture mem_q into rdata on reads only; rdata is unchanged on writes.
//   - Set the granted port's ack for the next cycle; go to IDLE.
//  Timing
//   - ack is high in cycle N+4 (IDLE) for exactly one cycle.
//   - Latency from req to ack: 4 cycles when the port is idle.
//   - Same port back-to-back: next request in N+5, next ack in N+9.
//   - The other port may be granted in N+4 (its req is not masked).
//  Completion handshake
//   - A transfer completes when req && ack.
//   - The requester deasserts req, or presents a new request, from N+5.
//   - The controller masks that port's req during its ack cycle, so the held req is never re-granted.
//  Boundaries
//   - Request fields are latched at grant.
//   - A req that drops or changes after grant does not abort the access; ack still pulses.
//   - Address wrap: none; the full 2^ADDRWIDTH range is passed through.
//   - Width: no arithmetic; widths are exact.
//   - Simultaneous req: strict alternation (P0, P1, P0, ...) while both stay asserted.
//   - Reset mid-access: the FSM and outputs clear immediately and no ack is issued.
//     A write already registered inside rom_mem (in ADDR or MEM) may still complete.
//     Requesters must re-issue after reset.
// STRUCTURE
//  - Package rom_sched_pkg: state enum (IDLE, ADDR, MEM, DATA) and localparam MEM_LAT=2.
//  - Sub-module rr_arb2: 2-input round-robin arbiter.
//    Inputs: req[1:0], mask[1:0], update, last_grant register. Output: one-hot grant.
//  - Everything else lives in the top-level FSM.
// TESTING
//  1. Reset, then P1 read at addr 0x0123, memory preloaded 0xA5:
//     p1_ack exactly 4 cycles after req; rdata=0xA5.
//  2. P0 write 0x3C to 0x0010, then P1 read 0x0010:
//     mem_wren high for exactly one cycle; mem_data held 2 cycles; rdata=0x3C.
//  3. P0 and P1 assert in the same cycle and hold 4 requests each:
//     grants go P0, P1, P0, P1, ...; no ack is ever high for both ports.
//  4. P1 keeps req high across its ack and issues the next address in N+5:
//     no duplicate access; the next ack comes 5 cycles after the previous one.
//  5. reset_n low in MEM state during a read:
//     no ack; all outputs 0 immediately; a new request after release completes normally.
//  6. Read at addr 0x3FFF (top of range) and write at 0x0000:
//     correct data; no aliasing between the two addresses.

Source files
------------

// File: rtl/rom_sched_pkg.sv
// rtl/rom_sched_pkg.sv - shared types and constants for the rom_mem port scheduler
package rom_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    MEM  = 2'd2,
    DATA = 2'd3
  } state_t;

  // Cycles from rom_mem registering the address to mem_q being valid.
  localparam int MEM_LAT = 2;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter with per-input mask
module rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       update,
  output logic [1:0] grant
);

  logic       last_grant;
  logic [1:0] eligible;

  always_comb begin
    eligible = req & ~mask;
    grant    = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Tie goes to whichever port did not win last time.
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (update && (grant != 2'b00)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/rom_mem_port_sched.sv
// rtl/rom_mem_port_sched.sv - shares one rom_mem port between a loader (P0) and a fetcher (P1)
module rom_mem_port_sched
  import rom_sched_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 14
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic [ADDRWIDTH-1:0] p0_addr,
  input  logic [DATAWIDTH-1:0] p0_wdata,
  output logic                 p0_ack,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic [ADDRWIDTH-1:0] p1_addr,
  input  logic [DATAWIDTH-1:0] p1_wdata,
  output logic                 p1_ack,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 busy,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_data,
  output logic                 mem_wren,
  input  logic [DATAWIDTH-1:0] mem_q
);

  state_t               state, state_nxt;
  logic                 we_q, we_nxt;
  logic                 sel_q, sel_nxt;
  logic [ADDRWIDTH-1:0] addr_nxt;
  logic [DATAWIDTH-1:0] data_nxt;
  logic [DATAWIDTH-1:0] rdata_nxt;
  logic                 wren_nxt;
  logic                 busy_nxt;
  logic                 ack0_nxt, ack1_nxt;
  logic [1:0]           grant;

  // A port is masked during its own ack cycle so a held req is not re-granted.
  rr_arb2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     ({p1_req, p0_req}),
    .mask    ({p1_ack, p0_ack}),
    .update  (state == IDLE),
    .grant   (grant)
  );

  always_comb begin
    state_nxt = state;
    we_nxt    = we_q;
    sel_nxt   = sel_q;
    addr_nxt  = mem_addr;
    data_nxt  = mem_data;
    rdata_nxt = rdata;
    wren_nxt  = 1'b0;
    busy_nxt  = busy;
    ack0_nxt  = 1'b0;
    ack1_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (grant != 2'b00) begin
          sel_nxt   = grant[1];
          we_nxt    = grant[1] ? p1_we    : p0_we;
          addr_nxt  = grant[1] ? p1_addr  : p0_addr;
          data_nxt  = grant[1] ? p1_wdata : p0_wdata;
          wren_nxt  = we_nxt;
          busy_nxt  = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        state_nxt = MEM;
      end
      MEM: begin
        state_nxt = DATA;
      end
      DATA: begin
        if (!we_q) begin
          rdata_nxt = mem_q;
        end
        ack0_nxt  = ~sel_q;
        ack1_nxt  = sel_q;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      sel_q    <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_wren <= 1'b0;
      rdata    <= '0;
      busy     <= 1'b0;
      p0_ack   <= 1'b0;
      p1_ack   <= 1'b0;
    end else begin
      state    <= state_nxt;
      we_q     <= we_nxt;
      sel_q    <= sel_nxt;
      mem_addr <= addr_nxt;
      mem_data <= data_nxt;
      mem_wren <= wren_nxt;
      rdata    <= rdata_nxt;
      busy     <= busy_nxt;
      p0_ack   <= ack0_nxt;
      p1_ack   <= ack1_nxt;
    end
  end

endmodule

// File: tb/tb_rom_mem_port_sched.sv
// tb/tb_rom_mem_port_sched.sv - scoreboard bench for rom_mem_port_sched
module tb_rom_mem_port_sched;

  localparam int DW = 8;
  localparam int AW = 14;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          p0_req = 1'b0, p0_we = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p0_ack;
  logic          p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p1_ack;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_wren;
  logic [DW-1:0] mem_q;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  rom_mem_port_sched #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .p0_req   (p0_req),
    .p0_we    (p0_we),
    .p0_addr  (p0_addr),
    .p0_wdata (p0_wdata),
    .p0_ack   (p0_ack),
    .p1_req   (p1_req),
    .p1_we    (p1_we),
    .p1_addr  (p1_addr),
    .p1_wdata (p1_wdata),
    .p1_ack   (p1_ack),
    .rdata    (rdata),
    .busy     (busy),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_wren (mem_wren),
    .mem_q    (mem_q)
  );

  // rom_mem port model: inputs registered, write and read one cycle later.
  logic [DW-1:0] mem_model [0:(1<<AW)-1];
  logic [AW-1:0] a_r;
  logic [DW-1:0] d_r;
  logic          w_r;
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clock) begin
    a_r <= mem_addr;
    d_r <= mem_data;
    w_r <= mem_wren;
    if (w_r) mem_model[a_r] <= d_r;
    else if (pl_we) mem_model[pl_addr] <= pl_data;
    mem_q <= mem_model[a_r];
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clock); #1;
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clock); #1;
    pl_we = 1'b0;
  endtask

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (port) begin
      p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
    end else begin
      p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
    end
  endtask

  // One access: returns req-to-ack latency (-1 on timeout), rdata at ack and write-strobe info.
  task automatic do_access(input bit port, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output int lat, output logic [DW-1:0] rd,
                           output int wren_cnt, output logic [DW-1:0] wd_first,
                           output logic [DW-1:0] wd_second);
    bit got = 0;
    bit prev_wren = 0;
    lat = 0; wren_cnt = 0; rd = '0; wd_first = '0; wd_second = '0;
    @(posedge clock); #1;
    drive(port, 1'b1, we, a, d);
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (prev_wren) wd_second = mem_data;
      prev_wren = mem_wren;
      if (mem_wren) begin
        wren_cnt++;
        wd_first = mem_data;
      end
      if ((port && p1_ack) || (!port && p0_ack)) begin
        rd = rdata;
        got = 1;
        break;
      end
      lat++;
    end
    if (!got) lat = -1;
    @(posedge clock); #1;
    drive(port, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset;
    @(negedge clock);
    tests_run++;
    if ({busy, p0_ack, p1_ack, mem_wren, mem_addr, mem_data, rdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got busy=%b acks=%b%b wren=%b addr=%h data=%h rdata=%h want all 0",
               busy, p0_ack, p1_ack, mem_wren, mem_addr, mem_data, rdata);
    end
    preload(14'h0123, 8'hA5);
    preload(14'h3FFF, 8'hC3);
    for (int i = 0; i < 4; i++) begin
      preload(14'h0200 + 14'(i), 8'h10 + 8'(i));
      preload(14'h0300 + 14'(i), 8'h80 + 8'(i));
    end
    preload(14'h0400, 8'h44);
    preload(14'h0401, 8'h45);
    preload(14'h0500, 8'h55);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    tests_run++;
    if ({busy, p0_ack, p1_ack, mem_wren} !== 4'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset got busy=%b acks=%b%b wren=%b want 0", busy, p0_ack, p1_ack, mem_wren);
    end
  endtask

  task automatic test_p1_read;
    int lat, wc;
    logic [DW-1:0] rd, w0, w1;
    exp_t e;
    sb.push_back('{port: 1'b1, data: 8'hA5});
    do_access(1'b1, 1'b0, 14'h0123, 8'h00, lat, rd, wc, w0, w1);
    e = sb.pop_front();
    tests_run++;
    if (lat !== 4) begin
      tests_failed++;
      $display("FAIL p1_read_latency got %0d want 4", lat);
    end
    tests_run++;
    if (rd !== e.data) begin
      tests_failed++;
      $display("FAIL p1_read_data got %h want %h", rd, e.data);
    end
    tests_run++;
    if (wc !== 0) begin
      tests_failed++;
      $display("FAIL p1_read_no_wren got %0d want 0", wc);
    end
  endtask

  task automatic test_write_then_read;
    int lat, wc;
    logic [DW-1:0] rd, w0, w1;
    exp_t e;
    sb.push_back('{port: 1'b0, data: 8'hA5});
    sb.push_back('{port: 1'b1, data: 8'h3C});
    do_access(1'b0, 1'b1, 14'h0010, 8'h3C, lat, rd, wc, w0, w1);
    e = sb.pop_front();
    tests_run++;
    if (wc !== 1) begin
      tests_failed++;
      $display("FAIL write_wren_cycles got %0d want 1", wc);
    end
    tests_run++;
    if (w0 !== 8'h3C || w1 !== 8'h3C) begin
      tests_failed++;
      $display("FAIL write_data_hold got %h,%h want 3c,3c", w0, w1);
    end
    tests_run++;
    if (lat !== 4 || rd !== e.data) begin
      tests_failed++;
      $display("FAIL write_ack got lat=%0d rdata=%h want lat=4 rdata=%h", lat, rd, e.data);
    end
    do_access(1'b1, 1'b0, 14'h0010, 8'h00, lat, rd, wc, w0, w1);
    e = sb.pop_front();
    tests_run++;
    if (rd !== e.data) begin
      tests_failed++;
      $display("FAIL read_after_write got %h want %h", rd, e.data);
    end
  endtask

  task automatic test_round_robin;
    int n0 = 0, n1 = 0, acks = 0, both = 0;
    bit upd0 = 0, upd1 = 0;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{port: 1'b0, data: 8'h10 + 8'(i)});
      sb.push_back('{port: 1'b1, data: 8'h80 + 8'(i)});
    end
    @(posedge clock); #1;
    drive(1'b0, 1'b1, 1'b0, 14'h0200, '0);
    drive(1'b1, 1'b1, 1'b0, 14'h0300, '0);
    for (int c = 0; c < 200 && acks < 8; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
      end
      if (upd0) begin
        n0++;
        if (n0 < 4) drive(1'b0, 1'b1, 1'b0, 14'h0200 + 14'(n0), '0);
        else drive(1'b0, 1'b0, 1'b0, '0, '0);
      end
      if (upd1) begin
        n1++;
        if (n1 < 4) drive(1'b1, 1'b1, 1'b0, 14'h0300 + 14'(n1), '0);
        else drive(1'b1, 1'b0, 1'b0, '0, '0);
      end
      @(negedge clock);
      upd0 = p0_ack;
      upd1 = p1_ack;
      if (p0_ack && p1_ack) both++;
      if ((p0_ack || p1_ack) && sb.size() > 0) begin
        e = sb.pop_front();
        acks++;
        tests_run++;
        if (p1_ack !== e.port) begin
          tests_failed++;
          $display("FAIL rr_order ack %0d got port %0d want port %0d", acks, p1_ack, e.port);
        end
        tests_run++;
        if (rdata !== e.data) begin
          tests_failed++;
          $display("FAIL rr_data ack %0d got %h want %h", acks, rdata, e.data);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    sb.delete();
    tests_run++;
    if (acks !== 8 || both !== 0) begin
      tests_failed++;
      $display("FAIL rr_complete got acks=%0d dual_acks=%0d want 8 and 0", acks, both);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_back_to_back;
    int t1 = -1, t2 = -1;
    exp_t e;
    sb.push_back('{port: 1'b1, data: 8'h44});
    sb.push_back('{port: 1'b1, data: 8'h45});
    @(posedge clock); #1;
    drive(1'b1, 1'b1, 1'b0, 14'h0400, '0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (p1_ack) begin t1 = cyc; break; end
    end
    e = sb.pop_front();
    tests_run++;
    if (t1 < 0 || rdata !== e.data) begin
      tests_failed++;
      $display("FAIL b2b_first got t=%0d rdata=%h want ack and %h", t1, rdata, e.data);
    end
    @(posedge clock); #1;
    drive(1'b1, 1'b1, 1'b0, 14'h0401, '0);
    @(negedge clock);
    tests_run++;
    if (busy !== 1'b0 || p1_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_no_regrant got busy=%b ack=%b want 0,0", busy, p1_ack);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (p1_ack) begin t2 = cyc; break; end
    end
    e = sb.pop_front();
    @(posedge clock); #1;
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    tests_run++;
    if (t2 - t1 !== 5 || t1 < 0 || t2 < 0) begin
      tests_failed++;
      $display("FAIL b2b_spacing got %0d want 5", t2 - t1);
    end
    tests_run++;
    if (rdata !== e.data) begin
      tests_failed++;
      $display("FAIL b2b_second_data got %h want %h", rdata, e.data);
    end
  endtask

  task automatic test_reset_mid_access;
    int acks = 0, lat, wc;
    logic [DW-1:0] rd, w0, w1;
    exp_t e;
    @(posedge clock); #1;
    drive(1'b1, 1'b1, 1'b0, 14'h0500, '0);
    repeat (3) @(negedge clock);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_busy got %b want 1", busy);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, p0_ack, p1_ack, mem_wren, mem_addr, mem_data, rdata} !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs got busy=%b wren=%b addr=%h data=%h rdata=%h want all 0",
               busy, mem_wren, mem_addr, mem_data, rdata);
    end
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (p0_ack || p1_ack) acks++;
    end
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (p0_ack || p1_ack) acks++;
    end
    tests_run++;
    if (acks !== 0) begin
      tests_failed++;
      $display("FAIL rst_mid_no_ack got %0d acks want 0", acks);
    end
    sb.push_back('{port: 1'b1, data: 8'h55});
    do_access(1'b1, 1'b0, 14'h0500, 8'h00, lat, rd, wc, w0, w1);
    e = sb.pop_front();
    tests_run++;
    if (lat !== 4 || rd !== e.data) begin
      tests_failed++;
      $display("FAIL rst_recover got lat=%0d rdata=%h want 4 and %h", lat, rd, e.data);
    end
  endtask

  task automatic test_boundary;
    int lat, wc;
    logic [DW-1:0] rd, w0, w1;
    exp_t e;
    bit [AW-1:0] addrs [6] = '{14'h0000, 14'h3FFF, 14'h0000, 14'h3FFF, 14'h0000, 14'h3FFF};
    bit          wes   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bit [DW-1:0] wds   [6] = '{8'h5A, 8'h00, 8'h00, 8'h96, 8'h00, 8'h00};
    bit [DW-1:0] exps  [6] = '{8'h55, 8'hC3, 8'h5A, 8'h5A, 8'h5A, 8'h96};
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{port: wes[i] ? 1'b0 : 1'b1, data: exps[i]});
      do_access(wes[i] ? 1'b0 : 1'b1, wes[i], addrs[i], wds[i], lat, rd, wc, w0, w1);
      e = sb.pop_front();
      tests_run++;
      if (lat !== 4 || rd !== e.data) begin
        tests_failed++;
        $display("FAIL boundary step %0d addr %h got lat=%0d rdata=%h want 4 and %h",
                 i, addrs[i], lat, rd, e.data);
      end
    end
  endtask

  initial begin
    test_reset;
    test_p1_read;
    test_write_then_read;
    test_round_robin;
    test_back_to_back;
    test_reset_mid_access;
    test_boundary;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
